// File: rtl/uart_rx_fifo_ctrl_if.sv
// Bundle of receiver-side strobes, FIFO read port and status for uart_rx_fifo_ctrl.
// slave is the controller's view; master is the receiver/register-file side.
interface uart_rx_fifo_ctrl_if #(
  parameter int AW = 4
);
  logic          fifo_write;
  logic [7:0]    rx_byte;
  logic          parity_err;
  logic          framing_error;
  logic          stop_strobe;
  logic          clear_parity;
  logic          clear_framing_error;
  logic          rd_en;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_parity_err;
  logic          rd_framing_err;
  logic [AW:0]   count;
  logic          afull;
  logic          overflow;
  logic          clear_overflow;
  logic          flush;

  modport slave (
    input  fifo_write, rx_byte, parity_err, framing_error, stop_strobe,
           rd_en, clear_overflow, flush,
    output clear_parity, clear_framing_error, rd_valid, rd_data,
           rd_parity_err, rd_framing_err, count, afull, overflow
  );

  modport master (
    output fifo_write, rx_byte, parity_err, framing_error, stop_strobe,
           rd_en, clear_overflow, flush,
    input  clear_parity, clear_framing_error, rd_valid, rd_data,
           rd_parity_err, rd_framing_err, count, afull, overflow
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive capture sequencer and first-word-fall-through FIFO.
// Define RX_ERR_TAG_EN to tag entries with parity/framing status and wait for the stop bit.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic clk,
  input  logic reset_n,
  uart_rx_fifo_ctrl_if.slave bus
);

`ifdef RX_ERR_TAG_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW + 1)'(AFULL_LEVEL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STOP = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] hold, hold_nxt;
  logic [EW-1:0] new_entry;
  logic          load, stop_hit, commit_req;
  logic          clr_par_q, clr_fe_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          full, do_read, wr_ok, ovf_set;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

`ifdef RX_ERR_TAG_EN
  assign new_entry = {1'b0, bus.parity_err, bus.rx_byte};
`else
  assign new_entry = bus.rx_byte;
  logic unused_sink;
  assign unused_sink = &{1'b0, bus.parity_err, bus.framing_error, bus.stop_strobe};
`endif

  // A second start strobe while waiting for the stop bit commits the held byte untagged.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    load       = 1'b0;
    stop_hit   = 1'b0;
    commit_req = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.fifo_write) begin
          load = 1'b1;
`ifdef RX_ERR_TAG_EN
          state_nxt = WAIT_STOP;
`else
          state_nxt = COMMIT;
`endif
        end
      end
`ifdef RX_ERR_TAG_EN
      WAIT_STOP: begin
        if (bus.stop_strobe) begin
          stop_hit  = 1'b1;
          state_nxt = COMMIT;
        end else if (!bus.fifo_write) begin
          commit_req = 1'b1;
          load       = 1'b1;
        end
      end
`endif
      COMMIT: begin
        commit_req = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (load) hold_nxt = new_entry;
`ifdef RX_ERR_TAG_EN
    if (stop_hit) hold_nxt[9] = bus.framing_error;
`endif
  end

  assign full    = (count_q == DEPTH_C);
  assign do_read = bus.rd_en && (count_q != '0);
  assign wr_ok   = commit_req && !bus.flush && (!full || do_read);
  assign ovf_set = commit_req && !bus.flush && full && !do_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold      <= '0;
      clr_par_q <= 1'b0;
      clr_fe_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      clr_par_q <= load;
      clr_fe_q  <= stop_hit;
    end
  end

  // Flush overrides any write or read landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_ok)   wr_ptr <= wr_ptr + AW'(1);
        if (do_read) rd_ptr <= rd_ptr + AW'(1);
        case ({wr_ok, do_read})
          2'b10:   count_q <= count_q + (AW + 1)'(1);
          2'b01:   count_q <= count_q - (AW + 1)'(1);
          default: count_q <= count_q;
        endcase
      end
      if (bus.clear_overflow) overflow_q <= 1'b0;
      else if (ovf_set)       overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= hold;
  end

  assign head                    = mem[rd_ptr];
  assign bus.rd_valid            = (count_q != '0);
  assign bus.rd_data             = bus.rd_valid ? head[7:0] : 8'h00;
  assign bus.count               = count_q;
  assign bus.afull               = (count_q >= AFULL_C);
  assign bus.overflow            = overflow_q;
`ifdef RX_ERR_TAG_EN
  assign bus.rd_parity_err       = bus.rd_valid & head[8];
  assign bus.rd_framing_err      = bus.rd_valid & head[9];
  assign bus.clear_parity        = clr_par_q;
  assign bus.clear_framing_error = clr_fe_q;
`else
  assign bus.rd_parity_err       = 1'b0;
  assign bus.rd_framing_err      = 1'b0;
  assign bus.clear_parity        = 1'b0;
  assign bus.clear_framing_error = 1'b0;
  logic unused_clr;
  assign unused_clr = &{1'b0, clr_par_q, clr_fe_q, stop_hit};
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed self-checking bench for uart_rx_fifo_ctrl; expectations follow RX_ERR_TAG_EN.
module tb_uart_rx_fifo_ctrl;

`ifdef RX_ERR_TAG_EN
  localparam logic TAG_EN = 1'b1;
`else
  localparam logic TAG_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   compare_count;
  int   mismatch_count;
  logic [7:0] sb [$];

  uart_rx_fifo_ctrl_if #(.AW(4)) bus ();

  uart_rx_fifo_ctrl #(.DEPTH(16), .AW(4), .AFULL_LEVEL(12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes one byte and returns while the controller is in its COMMIT cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic fe, input int delay);
    bus.fifo_write = 1'b0;
    bus.rx_byte    = data;
    bus.parity_err = par;
    tick();
    bus.fifo_write = 1'b1;
    bus.parity_err = 1'b0;
`ifdef RX_ERR_TAG_EN
    repeat (delay - 1) tick();
    bus.stop_strobe   = 1'b1;
    bus.framing_error = fe;
    tick();
    bus.stop_strobe   = 1'b0;
    bus.framing_error = 1'b0;
`else
    if (fe && delay < 0) $display("[TB] unreachable");
`endif
  endtask

  task automatic send_byte(input logic [7:0] data, input logic par, input logic fe);
    applyStimulus(data, par, fe, 2);
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] expected);
    checkOutput(tag, {24'h0, bus.rd_data}, {24'h0, expected});
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    reset_n            = 1'b0;
    bus.fifo_write     = 1'b1;
    bus.rx_byte        = 8'h00;
    bus.parity_err     = 1'b0;
    bus.framing_error  = 1'b0;
    bus.stop_strobe    = 1'b0;
    bus.rd_en          = 1'b0;
    bus.clear_overflow = 1'b0;
    bus.flush          = 1'b0;
    repeat (3) tick();

    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_afull", bus.afull, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
    checkOutput("rst_clear_parity", bus.clear_parity, 0);
    checkOutput("rst_clear_fe", bus.clear_framing_error, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_tags", {bus.rd_framing_err, bus.rd_parity_err}, 0);
    reset_n = 1'b1;
    tick();

    // Single byte with hand-timed stop strobe
    bus.fifo_write = 1'b0;
    bus.rx_byte    = 8'hA5;
    tick();
    bus.fifo_write = 1'b1;
    checkOutput("single_clr_par_t1", bus.clear_parity, TAG_EN);
    tick();
    checkOutput("single_clr_par_width", bus.clear_parity, 0);
`ifdef RX_ERR_TAG_EN
    checkOutput("single_wait_count", bus.count, 0);
    repeat (8) tick();
    bus.stop_strobe = 1'b1;
    tick();
    bus.stop_strobe = 1'b0;
    checkOutput("single_clr_fe_s1", bus.clear_framing_error, 1);
    checkOutput("single_s1_valid", bus.rd_valid, 0);
    tick();
    checkOutput("single_clr_fe_width", bus.clear_framing_error, 0);
`endif
    checkOutput("single_valid", bus.rd_valid, 1);
    checkOutput("single_count", bus.count, 1);
    checkOutput("single_tags", {bus.rd_framing_err, bus.rd_parity_err}, 0);
    pop_check("single_data", 8'hA5);
    checkOutput("single_count_after", bus.count, 0);

    // Error tags, then a clean byte behind it
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0);
    checkOutput("tag_parity", bus.rd_parity_err, TAG_EN);
    checkOutput("tag_framing", bus.rd_framing_err, TAG_EN);
    pop_check("tag_data", 8'h3C);
    checkOutput("clean_tags", {bus.rd_framing_err, bus.rd_parity_err}, 0);
    pop_check("clean_data", 8'h00);
    checkOutput("tag_count_empty", bus.count, 0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b0, 1'b0);
      checkOutput($sformatf("fill_count_%0d", i), bus.count, i + 1);
      checkOutput($sformatf("fill_afull_%0d", i), bus.afull, (i + 1 >= 12) ? 1 : 0);
    end
    checkOutput("fill_ovf_before", bus.overflow, 0);
    send_byte(8'hFF, 1'b0, 1'b0);
    checkOutput("fill_overflow", bus.overflow, 1);
    checkOutput("fill_count_ovf", bus.count, 16);
    for (int i = 0; i < 16; i++) pop_check($sformatf("fill_read_%0d", i), 8'(i));
    checkOutput("fill_drained", bus.count, 0);
    checkOutput("fill_ovf_sticky", bus.overflow, 1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    checkOutput("fill_ovf_cleared", bus.overflow, 0);

    // Full FIFO with a pop in the COMMIT cycle
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    applyStimulus(8'h77, 1'b0, 1'b0, 2);
    checkOutput("fullrd_head", bus.rd_data, 8'h10);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checkOutput("fullrd_count", bus.count, 16);
    checkOutput("fullrd_overflow", bus.overflow, 0);
    for (int i = 1; i < 16; i++) pop_check($sformatf("fullrd_read_%0d", i), 8'h10 + 8'(i));
    pop_check("fullrd_last", 8'h77);
    checkOutput("fullrd_empty", bus.count, 0);

    // Wrap-around with interleaved reads against a queue model
    for (int i = 0; i < 40; i++) begin
      send_byte(8'h40 + 8'(i), 1'b0, 1'b0);
      sb.push_back(8'h40 + 8'(i));
      checkOutput($sformatf("wrap_count_%0d", i), bus.count, sb.size());
      if (i % 4 != 0) pop_check($sformatf("wrap_read_%0d", i), sb.pop_front());
    end
    while (sb.size() > 0) pop_check("wrap_drain", sb.pop_front());
    checkOutput("wrap_empty", bus.count, 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checkOutput("empty_read_count", bus.count, 0);
    checkOutput("empty_read_valid", bus.rd_valid, 0);

    // Flush in the COMMIT cycle discards the entry
    applyStimulus(8'h55, 1'b0, 1'b0, 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checkOutput("flush_count", bus.count, 0);
    tick();
    checkOutput("flush_valid_later", bus.rd_valid, 0);

    // Async reset mid-frame drops the held byte
    bus.fifo_write = 1'b0;
    bus.rx_byte    = 8'h99;
    tick();
    bus.fifo_write = 1'b1;
    reset_n = 1'b0;
    #2;
    checkOutput("midrst_clr_par", bus.clear_parity, 0);
    reset_n = 1'b1;
    tick();
    bus.stop_strobe = 1'b1;
    tick();
    bus.stop_strobe = 1'b0;
    checkOutput("midrst_clr_fe", bus.clear_framing_error, 0);
    repeat (3) tick();
    checkOutput("midrst_count", bus.count, 0);
    checkOutput("midrst_valid", bus.rd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Receive-side sequencer and buffer for the UART receiver running in FIFO mode. It captures each byte strobed out by the async receiver and tags it with that byte's parity and framing status. It stores the tagged entry in a DEPTH-entry circular FIFO and drives the receiver's error-clear controls. It sits between the receiver and the APB register file, which pops entries through a first-word-fall-through read port.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- AW, 4, pointer width, log2(DEPTH)
- AFULL_LEVEL, 12, `afull` asserts when count >= AFULL_LEVEL; range 1..DEPTH

- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- fifo_write  input  1  active-low one-cycle strobe from receiver; rx_byte is valid in that cycle
- rx_byte  input  8  received data
- parity_err  input  1  receiver parity status, valid with fifo_write
- framing_error  input  1  receiver framing status, valid when stop_strobe=1
- stop_strobe  input  1  one-cycle pulse at end of stop bit
- clear_parity  output  1  one-cycle pulse clearing receiver parity_err
- clear_framing_error  output  1  one-cycle pulse clearing receiver framing_error
- rd_en  input  1  pop head entry; ignored when rd_valid=0
- rd_valid  output  1  FIFO not empty
- rd_data  output  8  head entry data
- rd_parity_err  output  1  head entry parity tag
- rd_framing_err  output  1  head entry framing tag
- count  output  AW+1  occupancy, 0..DEPTH
- afull  output  1  count >= AFULL_LEVEL
- overflow  output  1  sticky; set when an entry is dropped because the FIFO is full
- clear_overflow  input  1  clears overflow
- flush  input  1  synchronous FIFO clear

## Operation
- Capture state machine: IDLE, WAIT_STOP, COMMIT. Reset state is IDLE.
- IDLE: when fifo_write=0, load holding register {rx_byte, parity_err} and go to WAIT_STOP.
- WAIT_STOP: when stop_strobe=1, latch framing_error into the holding tag and go to COMMIT.
- WAIT_STOP, second fifo_write=0 arrives with no stop_strobe: commit the held entry with framing tag 0, load the new byte, and stay in WAIT_STOP.
- COMMIT: write the holding register at the write pointer, then return to IDLE.
- COMMIT, FIFO full and rd_en=0: drop the entry and set overflow. The old contents are preserved.
- COMMIT, FIFO full and rd_en=1 in the same cycle: the write is accepted and count is unchanged.
- Pointers are AW bits and wrap modulo DEPTH. count is updated as +1 on write only, -1 on read only, and 0 change on both.
- rd_data, rd_parity_err and rd_framing_err show the head entry combinationally from storage. rd_en advances the read pointer on the same edge.
- rd_en with rd_valid=0 has no effect. Writes never underflow.
- flush clears the pointers and count. It does not change the state machine, the holding register, or overflow. If flush coincides with a COMMIT write, flush wins and the entry is discarded.
- overflow: clear_overflow has priority over a simultaneous set.
- Reset values: rd_valid=0, count=0, afull=0, overflow=0, clear_parity=0, clear_framing_error=0, rd_data=0, and both rd tags 0. Storage contents are don't-care.
- Reset asserted mid-frame discards the holding register and returns the state machine to IDLE.

## Timing
- fifo_write sampled low at edge T: state=WAIT_STOP and clear_parity=1 during cycle T+1, one cycle wide.
- stop_strobe sampled at edge S: state=COMMIT and clear_framing_error=1 during cycle S+1.
- Entry written at edge S+1 (end of the COMMIT cycle): rd_valid=1 and count incremented from cycle S+2.
- All outputs are registered except rd_data and the rd tags, which are a combinational read of registered storage.
- afull and rd_valid are derived from the registered count, so they update in the same cycle as count.

## Configuration
- RX_ERR_TAG_EN defined: entries are 10 bits {framing, parity, data}, and the full state machine above applies.
- RX_ERR_TAG_EN undefined:
  - entries are 8 bits;
  - WAIT_STOP is skipped, so COMMIT follows IDLE directly (entry visible at T+2);
  - rd_parity_err, rd_framing_err, clear_parity and clear_framing_error are tied 0;
  - stop_strobe, parity_err and framing_error are ignored.

## Test plan
- Single byte: 0xA5 strobed, stop_strobe 10 cycles later with framing_error=0.
  - Expect clear_parity at T+1 and clear_framing_error at S+1.
  - Expect rd_valid and rd_data=0xA5 at S+2, tags 0.
  - Expect count 0→1, then back to 0 after rd_en.
- Error tags: byte 0x3C with parity_err=1, framing_error=1 at stop_strobe.
  - Expect a head entry with both tags set.
  - The next byte 0x00, sent with clean status, must carry tags 0.
- Fill and overflow (DEPTH=16): write 0x00..0x0F.
  - Expect count=16 and afull asserted at the 12th write.
  - A 17th byte 0xFF sets overflow, and reads then return 0x00..0x0F in order.
  - clear_overflow drops overflow.
- Full with simultaneous read: FIFO full, rd_en asserted in the COMMIT cycle of byte 0x77.
  - Expect count to stay 16, overflow to stay 0, and 0x77 to be read last.
- Wrap-around: 40 bytes (an incrementing pattern) interleaved with reads.
  - Expect in-order data and count never above 16.
  - rd_en while empty must leave count at 0.
- Disruption: flush coincident with COMMIT discards the entry (count=0).
  - reset_n pulsed low while in WAIT_STOP returns the state machine to IDLE, and no entry appears after the following stop_strobe.
